// File: rtl/alu_taylor_osc_seq.sv
// Phase-accumulator sequencer for the Taylor sin/cos ALU.
// Each sample strobe walks through all voices. An enabled voice has its phase
// reduced to one quadrant and sent to the ALU as a sin/cos request; the
// result comes back with its sign restored. A disabled voice emits 0.
// The voice's phase advances only after its sample is produced.
module alu_taylor_osc_seq #(
    parameter int N_VOICES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_stb,
    input  logic [N_VOICES-1:0]        voice_en,
    input  logic [24*N_VOICES-1:0]     phase_inc_flat,
    output logic                       calc_do,
    output logic [2:0]                 calc_func_sel,
    output logic signed [17:0]         calc_x,
    input  logic                       calc_done,
    input  logic signed [17:0]         calc_result,
    output logic                       sample_valid,
    output logic signed [17:0]         sample_out,
    output logic [3:0]                 sample_idx,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       overrun
);

    localparam int         VW     = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam logic [3:0] LAST_V = 4'(N_VOICES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_SKIP
    } state_t;

    // Map the quadrant-local phase bits to a Q2.16 angle in [0, pi/2).
    // 102943 is pi/2 in Q16; the 17-bit fraction is scaled and truncated.
    function automatic logic [17:0] reduce_angle(input logic [23:0] ph);
        logic [33:0] prod;
        prod = 34'(ph[21:5]) * 34'd102943;
        return {1'b0, prod[33:17]};
    endfunction

    // Two's-complement negate. The most negative code has no positive
    // counterpart, so it clamps to the largest positive value.
    function automatic logic signed [17:0] neg_sat(input logic signed [17:0] x);
        if (x == -18'sd131072)
            return 18'sd131071;
        else
            return -x;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         v_q, v_d;
    logic [23:0]        phase_acc_q [N_VOICES];
    logic [23:0]        phase_acc_d [N_VOICES];
    logic signed [17:0] calc_x_q, calc_x_d;
    logic [2:0]         func_q, func_d;
    logic               neg_q, neg_d;
    logic               sample_valid_q, sample_valid_d;
    logic signed [17:0] sample_out_q, sample_out_d;
    logic [3:0]         sample_idx_q, sample_idx_d;
    logic               frame_done_q, frame_done_d;
    logic               overrun_q, overrun_d;

    logic [VW-1:0]      vi;
    logic [23:0]        cur_phase;
    logic [23:0]        inc_sel;

    assign vi        = v_q[VW-1:0];
    assign cur_phase = phase_acc_q[vi];
    assign inc_sel   = phase_inc_flat[24*vi +: 24];

    // Next-state, voice bookkeeping and output register inputs.
    always_comb begin
        state_d        = state_q;
        v_d            = v_q;
        phase_acc_d    = phase_acc_q;
        calc_x_d       = calc_x_q;
        func_d         = func_q;
        neg_d          = neg_q;
        sample_valid_d = 1'b0;
        sample_out_d   = sample_out_q;
        sample_idx_d   = sample_idx_q;
        frame_done_d   = 1'b0;
        // The frame_done cycle is still part of the previous frame, so a
        // strobe there is rejected like any other strobe during a frame.
        overrun_d      = sample_stb && ((state_q != S_IDLE) || frame_done_q);

        case (state_q)
            S_IDLE: begin
                if (sample_stb && !frame_done_q) begin
                    v_d     = 4'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!voice_en[vi]) begin
                    state_d = S_SKIP;
                end else begin
                    // Quadrants 1 and 3 use cosine; quadrants 2 and 3 are negated.
                    calc_x_d = reduce_angle(cur_phase);
                    func_d   = {2'b00, cur_phase[22]};
                    neg_d    = cur_phase[23];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (calc_done) begin
                    sample_out_d    = neg_q ? neg_sat(calc_result) : calc_result;
                    sample_valid_d  = 1'b1;
                    sample_idx_d    = v_q;
                    phase_acc_d[vi] = cur_phase + inc_sel;
                    if (v_q == LAST_V) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        v_d     = v_q + 4'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_SKIP: begin
                sample_out_d   = '0;
                sample_valid_d = 1'b1;
                sample_idx_d   = v_q;
                if (v_q == LAST_V) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    v_d     = v_q + 4'd1;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, phase accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            v_q            <= '0;
            for (int i = 0; i < N_VOICES; i++)
                phase_acc_q[i] <= '0;
            calc_x_q       <= '0;
            func_q         <= '0;
            neg_q          <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_out_q   <= '0;
            sample_idx_q   <= '0;
            frame_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            v_q            <= v_d;
            phase_acc_q    <= phase_acc_d;
            calc_x_q       <= calc_x_d;
            func_q         <= func_d;
            neg_q          <= neg_d;
            sample_valid_q <= sample_valid_d;
            sample_out_q   <= sample_out_d;
            sample_idx_q   <= sample_idx_d;
            frame_done_q   <= frame_done_d;
            overrun_q      <= overrun_d;
        end
    end

    assign calc_do       = (state_q == S_ISSUE);
    assign busy          = (state_q != S_IDLE);
    assign calc_x        = calc_x_q;
    assign calc_func_sel = func_q;
    assign sample_valid  = sample_valid_q;
    assign sample_out    = sample_out_q;
    assign sample_idx    = sample_idx_q;
    assign frame_done    = frame_done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_alu_taylor_osc_seq.sv
// Directed bench for alu_taylor_osc_seq with a behavioural ALU stand-in.
module tb_alu_taylor_osc_seq;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_stb;
    logic [3:0]         voice_en;
    logic [95:0]        phase_inc_flat;
    logic               calc_do;
    logic [2:0]         calc_func_sel;
    logic signed [17:0] calc_x;
    logic               calc_done;
    logic signed [17:0] calc_result;
    logic               sample_valid;
    logic signed [17:0] sample_out;
    logic [3:0]         sample_idx;
    logic               frame_done;
    logic               busy;
    logic               overrun;

    int total = 0;
    int bad   = 0;

    // ALU stand-in controls
    int                 alu_lat = 2;
    logic signed [17:0] alu_val = 18'sh08000;

    // Observed traffic
    logic [2:0]         req_func [$];
    logic [17:0]        req_x    [$];
    logic signed [17:0] s_out    [$];
    logic [3:0]         s_idx    [$];
    logic               s_fd     [$];
    int                 frame_cnt = 0;
    int                 ovr_cnt   = 0;

    alu_taylor_osc_seq #(.N_VOICES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_stb     (sample_stb),
        .voice_en       (voice_en),
        .phase_inc_flat (phase_inc_flat),
        .calc_do        (calc_do),
        .calc_func_sel  (calc_func_sel),
        .calc_x         (calc_x),
        .calc_done      (calc_done),
        .calc_result    (calc_result),
        .sample_valid   (sample_valid),
        .sample_out     (sample_out),
        .sample_idx     (sample_idx),
        .frame_done     (frame_done),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // ALU stand-in: answers each request after alu_lat cycles
    initial begin
        calc_done   = 1'b0;
        calc_result = '0;
        forever begin
            @(negedge clk);
            if (calc_do === 1'b1) begin
                for (int k = 0; k < alu_lat; k++) @(negedge clk);
                calc_done   = 1'b1;
                calc_result = alu_val;
                @(negedge clk);
                calc_done   = 1'b0;
                calc_result = '0;
            end
        end
    end

    // Monitor: records requests, samples, frames and overruns
    initial begin
        forever begin
            @(negedge clk);
            if (calc_do === 1'b1) begin
                req_func.push_back(calc_func_sel);
                req_x.push_back(calc_x);
            end
            if (sample_valid === 1'b1) begin
                s_out.push_back(sample_out);
                s_idx.push_back(sample_idx);
                s_fd.push_back(frame_done);
            end
            if (frame_done === 1'b1) frame_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic signed [39:0] obs,
                       input logic signed [39:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        req_func.delete();
        req_x.delete();
        s_out.delete();
        s_idx.delete();
        s_fd.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic strobe();
        @(negedge clk);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int start;
        start = frame_cnt;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_cnt > start) break;
        end
        chk(tag, frame_cnt - start, 1);
    endtask

    task automatic wait_calc_do(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (calc_do === 1'b1) break;
        end
        chk(tag, calc_do, 1);
    endtask

    initial begin
        reset          = 1'b1;
        sample_stb     = 1'b0;
        voice_en       = 4'b0001;
        phase_inc_flat = {72'd0, 24'h400000};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_sample_idx", sample_idx, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_calc_do", calc_do, 0);
        chk("rst_calc_x", calc_x, 0);
        chk("rst_calc_func", calc_func_sel, 0);

        // Quadrant sweep: one voice stepping pi/2 per frame
        clear_logs();
        alu_val = 18'sh08000;
        for (int f = 0; f < 4; f++) begin
            strobe();
            wait_frame("sweep_frame");
        end
        chk("sweep_req_count", req_func.size(), 4);
        chk("sweep_sample_count", s_out.size(), 16);
        chk("sweep_func0", req_func[0], 0);
        chk("sweep_func1", req_func[1], 1);
        chk("sweep_func2", req_func[2], 0);
        chk("sweep_func3", req_func[3], 1);
        chk("sweep_x0", req_x[0], 0);
        chk("sweep_x1", req_x[1], 0);
        chk("sweep_x2", req_x[2], 0);
        chk("sweep_x3", req_x[3], 0);
        chk("sweep_out0", s_out[0], 32768);
        chk("sweep_out1", s_out[4], 32768);
        chk("sweep_out2", s_out[8], -32768);
        chk("sweep_out3", s_out[12], -32768);
        chk("sweep_skip_out", s_out[1], 0);

        // Reduction: pi/4 step gives angle 51471 on the second request
        clear_logs();
        phase_inc_flat = {72'd0, 24'h200000};
        strobe();
        wait_frame("reduce_frame1");
        strobe();
        wait_frame("reduce_frame2");
        chk("reduce_x0", req_x[0], 0);
        chk("reduce_x1", req_x[1], 51471);
        chk("reduce_func1", req_func[1], 0);

        // Saturation: -(-131072) in quadrant 2 clamps to +131071
        do_reset();
        clear_logs();
        phase_inc_flat = {72'd0, 24'h400000};
        alu_val = -18'sd131072;
        for (int f = 0; f < 3; f++) begin
            strobe();
            wait_frame("sat_frame");
        end
        chk("sat_q0_passthru", s_out[0], -131072);
        chk("sat_q2_func", req_func[2], 0);
        chk("sat_q2_out", s_out[8], 131071);

        // Mixed enables: voices 1 and 3 only
        do_reset();
        clear_logs();
        voice_en = 4'b1010;
        alu_val  = 18'sd1234;
        strobe();
        wait_frame("mixed_frame");
        chk("mixed_calc_do_count", req_func.size(), 2);
        chk("mixed_sample_count", s_out.size(), 4);
        chk("mixed_idx0", s_idx[0], 0);
        chk("mixed_idx1", s_idx[1], 1);
        chk("mixed_idx2", s_idx[2], 2);
        chk("mixed_idx3", s_idx[3], 3);
        chk("mixed_out0", s_out[0], 0);
        chk("mixed_out1", s_out[1], 1234);
        chk("mixed_out2", s_out[2], 0);
        chk("mixed_out3", s_out[3], 1234);
        chk("mixed_fd2", s_fd[2], 0);
        chk("mixed_fd3", s_fd[3], 1);

        // Overrun: strobe while waiting on the ALU
        clear_logs();
        ovr_cnt  = 0;
        voice_en = 4'b1111;
        alu_val  = 18'sd777;
        strobe();
        wait_calc_do("ovr_first_req");
        @(negedge clk);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        wait_frame("ovr_frame");
        repeat (20) @(negedge clk);
        chk("ovr_pulse_count", ovr_cnt, 1);
        chk("ovr_sample_count", s_out.size(), 4);
        chk("ovr_last_idx", s_idx[3], 3);
        chk("ovr_out0", s_out[0], 777);
        chk("ovr_idle_after", busy, 0);

        // Reset while waiting; the late ALU answer must be dropped
        voice_en       = 4'b0001;
        phase_inc_flat = {72'd0, 24'h123456};
        alu_val        = 18'sd5000;
        alu_lat        = 6;
        strobe();
        wait_calc_do("rstw_req");
        chk("rstw_pre_func", calc_func_sel, 1);
        clear_logs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rstw_no_sample", s_out.size(), 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_sample_out", sample_out, 0);
        chk("rstw_calc_x", calc_x, 0);
        chk("rstw_calc_func", calc_func_sel, 0);
        chk("rstw_sample_idx", sample_idx, 0);
        alu_lat = 2;
        clear_logs();
        strobe();
        wait_frame("rstw_frame1");
        strobe();
        wait_frame("rstw_frame2");
        chk("rstw_x0", req_x[0], 0);
        chk("rstw_func0", req_func[0], 0);
        chk("rstw_out0", s_out[0], 5000);
        chk("rstw_x1", req_x[1], 29281);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
